dma_crossover_engine: RTL

Parametrised dual-moving-average crossover engine for the tick-to-signal path. It takes a qualified price stream and keeps power-of-two short and long windows in one circular buffer. It registers both averages and drives a position state machine that emits one-cycle buy/sell pulses with programmable hysteresis. Successor to the fixed 8-bit dual-average block: adds width/depth parameters, input valid qualification, warm-up gating, hysteresis, position tracking and a signal-age counter.

---
 rtl/dma_crossover_engine.sv | 114 +++++++++++
 1 files changed

// File: rtl/dma_crossover_engine.sv
// dma_crossover_engine: dual moving-average crossover engine with hysteresis, position FSM and signal-age counter
module dma_crossover_engine #(
  parameter int PRICE_W    = 8,
  parameter int SHORT_LOG2 = 1,
  parameter int LONG_LOG2  = 2,
  parameter int HYST       = 0,
  parameter int LAT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               price_valid,
  input  logic [PRICE_W-1:0] price_in,
  output logic [PRICE_W-1:0] short_ma,
  output logic [PRICE_W-1:0] long_ma,
  output logic               ma_valid,
  output logic               buy_signal,
  output logic               sell_signal,
  output logic [1:0]         position,
  output logic [LAT_W-1:0]   latency_counter
);
  localparam int DEPTH = 1 << LONG_LOG2;
  localparam int SUM_W = PRICE_W + LONG_LOG2;
  localparam int CNT_W = LONG_LOG2 + 1;
  localparam logic [PRICE_W:0] HYST_E = (PRICE_W+1)'(HYST);

  if (LONG_LOG2 <= SHORT_LOG2) begin : g_bad_window
    $fatal(1, "LONG_LOG2 must exceed SHORT_LOG2");
  end

  typedef enum logic [1:0] {WARMUP, FLAT, POS_LONG, POS_SHORT} pos_t;

  logic [PRICE_W-1:0]   buf_q [DEPTH];
  logic [PRICE_W-1:0]   buf_d [DEPTH];
  logic [LONG_LOG2-1:0] wr_ptr_q, wr_ptr_d, ev_s_ptr;
  logic [SUM_W-1:0]     short_sum_q, short_sum_d, long_sum_q, long_sum_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PRICE_W-1:0]   short_ma_q, short_ma_d, long_ma_q, long_ma_d;
  logic                 ma_valid_q, ma_valid_d, buy_q, buy_d, sell_q, sell_d;
  pos_t                 pos_q, pos_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [PRICE_W:0]     s_e, l_e;
  logic                 full, up, dn;

  always_comb begin
    buf_d       = buf_q;
    ev_s_ptr    = wr_ptr_q - LONG_LOG2'(2**SHORT_LOG2);
    // Evicted samples read 0 during warm-up because the buffer is cleared at reset.
    short_sum_d = price_valid ? short_sum_q + SUM_W'(price_in) - SUM_W'(buf_q[ev_s_ptr]) : short_sum_q;
    long_sum_d  = price_valid ? long_sum_q + SUM_W'(price_in) - SUM_W'(buf_q[wr_ptr_q]) : long_sum_q;
    if (price_valid) buf_d[wr_ptr_q] = price_in;
    wr_ptr_d    = price_valid ? wr_ptr_q + 1'b1 : wr_ptr_q;
    cnt_d       = (price_valid && cnt_q != CNT_W'(DEPTH)) ? cnt_q + CNT_W'(1) : cnt_q;
    full        = cnt_d == CNT_W'(DEPTH);
    short_ma_d  = price_valid ? PRICE_W'(short_sum_d >> SHORT_LOG2) : short_ma_q;
    long_ma_d   = price_valid ? PRICE_W'(long_sum_d >> LONG_LOG2) : long_ma_q;
    ma_valid_d  = price_valid && full;
    s_e         = {1'b0, short_ma_d};
    l_e         = {1'b0, long_ma_d};
    up          = s_e > l_e + HYST_E;
    dn          = s_e + HYST_E < l_e;
    pos_d       = pos_q;
    buy_d       = 1'b0;
    sell_d      = 1'b0;
    if (price_valid) begin
      if (pos_q == WARMUP) pos_d = full ? FLAT : WARMUP;
      else if (up && pos_q != POS_LONG) begin
        pos_d = POS_LONG;
        buy_d = 1'b1;
      end else if (dn && pos_q != POS_SHORT) begin
        pos_d  = POS_SHORT;
        sell_d = 1'b1;
      end
    end
    lat_d = (buy_d || sell_d) ? '0 : (&lat_q ? lat_q : lat_q + LAT_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      short_sum_q <= '0;
      long_sum_q  <= '0;
      cnt_q       <= '0;
      short_ma_q  <= '0;
      long_ma_q   <= '0;
      ma_valid_q  <= 1'b0;
      buy_q       <= 1'b0;
      sell_q      <= 1'b0;
      pos_q       <= WARMUP;
      lat_q       <= '0;
    end else begin
      buf_q       <= buf_d;
      wr_ptr_q    <= wr_ptr_d;
      short_sum_q <= short_sum_d;
      long_sum_q  <= long_sum_d;
      cnt_q       <= cnt_d;
      short_ma_q  <= short_ma_d;
      long_ma_q   <= long_ma_d;
      ma_valid_q  <= ma_valid_d;
      buy_q       <= buy_d;
      sell_q      <= sell_d;
      pos_q       <= pos_d;
      lat_q       <= lat_d;
    end
  end

  assign short_ma        = short_ma_q;
  assign long_ma         = long_ma_q;
  assign ma_valid        = ma_valid_q;
  assign buy_signal      = buy_q;
  assign sell_signal     = sell_q;
  assign position        = pos_q;
  assign latency_counter = lat_q;
endmodule
